keypad_entry_controller: RTL

Parametrised successor to the timer input-control block for the microwave controller. It synchronises and debounces the ten keypad lines, priority-encodes them, and shifts accepted digits into a DIGITS-deep BCD entry register. It also generates the 1 Hz time-base by clock division and muxes it onto a single pulse output feeding the downstream timer. The block sits between the keypad and the countdown timer, with enablen selecting entry mode or run mode.

---
 rtl/keypad_entry_controller_pkg.sv | 30 +++
 rtl/keypad_entry_controller_pulse_divider.sv | 35 +++
 rtl/keypad_entry_controller.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module  : keypad_entry_controller_pkg
// Brief   : Shared types, constants and key encoder for the keypad entry block
// Revision: 1.0 - initial release
// ============================================================================
package keypad_entry_controller_pkg;

    localparam int BCD_W    = 4;
    localparam int NUM_KEYS = 10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Ascending scan so the highest-numbered pressed key wins
    function automatic logic [BCD_W-1:0] f_encode(input logic [NUM_KEYS-1:0] i_keys);
        logic [BCD_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (i_keys[i]) v = BCD_W'(i);
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_entry_controller_pulse_divider.sv
`default_nettype none
// ============================================================================
// Module  : pulse_divider
// Brief   : Free-running divide-by-DIVIDE counter, held at zero while idle
// Revision: 1.0 - initial release
// ============================================================================
module pulse_divider #(
    parameter int DIVIDE = 100
) (
    input  logic clock_100Hz,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int              CNT_W  = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DIVIDE - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock_100Hz or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (!run || (r_count == c_LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Combinational so the registered output in the parent lands on the DIVIDE-th cycle
    assign tick = run && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/keypad_entry_controller.sv
`default_nettype none
// ============================================================================
// Module  : keypad_entry_controller
// Brief   : Keypad sync/debounce, BCD entry shift register and 1 Hz pulse mux
// Revision: 1.0 - initial release
// ============================================================================
module keypad_entry_controller
    import keypad_entry_controller_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int DIVIDE   = 100,
    parameter int DEBOUNCE = 3
) (
    input  logic                      clock_100Hz,
    input  logic                      reset,
    input  logic [NUM_KEYS-1:0]       keypad,
    input  logic                      enablen,
    input  logic                      clear_entry,
    output logic [BCD_W*DIGITS-1:0]   digits,
    output logic [BCD_W-1:0]          D,
    output logic                      loadn,
    output logic                      key_valid,
    output logic                      entry_full,
    output logic                      pgt_1Hz
);

    localparam int               DB_W       = $clog2(DEBOUNCE + 1);
    localparam int               CNT_W      = $clog2(DIGITS + 1);
    localparam logic [DB_W-1:0]  c_DB_LAST  = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] c_FULL     = CNT_W'(DIGITS);

    logic [NUM_KEYS-1:0]     r_sync1;
    logic [NUM_KEYS-1:0]     r_sync2;
    state_t                  r_state;
    logic [BCD_W-1:0]        r_cand;
    logic [DB_W-1:0]         r_db_cnt;
    logic [BCD_W-1:0]        r_D;
    logic                    r_loadn;
    logic                    r_key_valid;
    logic                    r_pgt;
    logic [BCD_W*DIGITS-1:0] r_digits;
    logic [CNT_W-1:0]        r_count;
    logic                    r_full;

    logic                    w_any;
    logic [BCD_W-1:0]        w_code;
    logic                    w_accept;
    logic                    w_tick;
    logic [BCD_W*DIGITS-1:0] w_shifted;

    always_ff @(posedge clock_100Hz or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= keypad;
            r_sync2 <= r_sync1;
        end
    end

    assign w_any  = |r_sync2;
    assign w_code = f_encode(r_sync2);

    // Final stable cycle of a debounce: the FSM and the entry register both act on it
    assign w_accept = !enablen && (r_state == ST_DEBOUNCE) && w_any &&
                      (w_code == r_cand) && (r_db_cnt == c_DB_LAST);

    pulse_divider #(
        .DIVIDE (DIVIDE)
    ) u_divider (
        .clock_100Hz (clock_100Hz),
        .reset       (reset),
        .run         (enablen),
        .tick        (w_tick)
    );

    always_ff @(posedge clock_100Hz or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cand      <= '0;
            r_db_cnt    <= '0;
            r_D         <= '0;
            r_loadn     <= 1'b1;
            r_key_valid <= 1'b0;
            r_pgt       <= 1'b0;
        end else begin
            r_key_valid <= w_accept;
            r_pgt       <= enablen ? w_tick : w_accept;
            if (w_accept) r_D <= r_cand;

            if (enablen) begin
                r_state  <= ST_IDLE;
                r_loadn  <= 1'b1;
                r_db_cnt <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_any) begin
                            r_state  <= ST_DEBOUNCE;
                            r_cand   <= w_code;
                            r_db_cnt <= '0;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (!w_any) begin
                            r_state <= ST_IDLE;
                        end else if (w_code != r_cand) begin
                            r_cand   <= w_code;
                            r_db_cnt <= '0;
                        end else if (w_accept) begin
                            r_state <= ST_PRESSED;
                            r_loadn <= 1'b0;
                        end else begin
                            r_db_cnt <= r_db_cnt + 1'b1;
                        end
                    end
                    ST_PRESSED: begin
                        if (!w_any) begin
                            r_state  <= ST_RELEASE;
                            r_db_cnt <= '0;
                        end
                    end
                    ST_RELEASE: begin
                        if (w_any) begin
                            r_db_cnt <= '0;
                        end else if (r_db_cnt == c_DB_LAST) begin
                            r_state <= ST_IDLE;
                            r_loadn <= 1'b1;
                        end else begin
                            r_db_cnt <= r_db_cnt + 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        w_shifted              = r_digits << BCD_W;
        w_shifted[BCD_W-1:0]   = r_cand;
    end

    // Clear outranks a coincident acceptance; a full register drops new keys
    always_ff @(posedge clock_100Hz or posedge reset) begin
        if (reset) begin
            r_digits <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else if (clear_entry) begin
            r_digits <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else if (w_accept && (r_count != c_FULL)) begin
            r_digits <= w_shifted;
            r_count  <= r_count + 1'b1;
            r_full   <= ((r_count + 1'b1) == c_FULL);
        end
    end

    assign digits     = r_digits;
    assign D          = r_D;
    assign loadn      = r_loadn;
    assign key_valid  = r_key_valid;
    assign entry_full = r_full;
    assign pgt_1Hz    = r_pgt;

endmodule
`default_nettype wire
